// File: rtl/cmp_pkg.sv
// Shared types and constants for the cascaded magnitude comparator.
package cmp_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Cascade seed at the LS slice: with nothing below it, the operands compare equal.
  localparam cmp_flags_t CMP_CASCADE_INIT = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

endpackage

// File: rtl/comp4_slice.sv
// One 4-bit 7485-style comparator slice; unequal nibbles decide, otherwise pass cascade-in.
module comp4_slice
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  cmp_flags_t         cas_i,
  output cmp_flags_t         flags_o
);

  always_comb begin
    flags_o = cas_i;
    if (a_i > b_i) begin
      flags_o = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};
    end else if (a_i < b_i) begin
      flags_o = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
    end
  end

endmodule

// File: rtl/comp8_registered.sv
// Registered magnitude comparator built from a cascade of 4-bit slices; signed mode
// flips the operand MSBs so two's-complement order matches unsigned order.
module comp8_registered
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             L,
  output logic             EQ,
  output logic             G
);

  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic [WIDTH-1:0]        a_cmp;
  logic [WIDTH-1:0]        b_cmp;
  cmp_flags_t [NSLICE:0]   cas;
  cmp_flags_t              flags_q;
  logic                    out_valid_q;

  // Offset-binary: inverting the sign bit maps signed order onto unsigned order.
  assign a_cmp = {A[WIDTH-1] ^ is_signed, A[WIDTH-2:0]};
  assign b_cmp = {B[WIDTH-1] ^ is_signed, B[WIDTH-2:0]};

  assign cas[0] = CMP_CASCADE_INIT;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    comp4_slice u_slice (
      .a_i    (a_cmp[i*SLICE +: SLICE]),
      .b_i    (b_cmp[i*SLICE +: SLICE]),
      .cas_i  (cas[i]),
      .flags_o(cas[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        flags_q <= cas[NSLICE];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign L         = flags_q.lt;
  assign EQ        = flags_q.eq;
  assign G         = flags_q.gt;

endmodule

// File: tb/tb_comp8_registered.sv
// Self-checking bench for comp8_registered: directed vectors, reset and valid gating,
// then randomized compares against an integer-arithmetic reference model.
module tb_comp8_registered;

  localparam logic [2:0] FL = 3'b100;
  localparam logic [2:0] FE = 3'b010;
  localparam logic [2:0] FG = 3'b001;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       is_signed;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       L;
  logic       EQ;
  logic       G;

  int n_checks = 0;
  int n_errors = 0;

  logic       exp_v;
  logic [2:0] exp_f;

  // {is_signed, A, B, expected {L,EQ,G}}
  logic [19:0] dir_tbl [16] = '{
    {1'b0, 8'h11, 8'h11, FE}, {1'b0, 8'h12, 8'h11, FG}, {1'b0, 8'h44, 8'h10, FG},
    {1'b0, 8'h30, 8'h31, FL}, {1'b0, 8'h11, 8'h10, FG}, {1'b0, 8'h05, 8'h14, FL},
    {1'b0, 8'h00, 8'h00, FE}, {1'b0, 8'h10, 8'h0F, FG}, {1'b0, 8'h3A, 8'h3B, FL},
    {1'b0, 8'hFF, 8'hFF, FE}, {1'b1, 8'h80, 8'h7F, FL}, {1'b1, 8'hFF, 8'h00, FL},
    {1'b1, 8'h01, 8'hFF, FG}, {1'b0, 8'h80, 8'h7F, FG}, {1'b0, 8'hFF, 8'h00, FG},
    {1'b0, 8'h01, 8'hFF, FL}
  };

  comp8_registered #(.WIDTH(8), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .is_signed(is_signed),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .L        (L),
    .EQ       (EQ),
    .G        (G)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] ref_cmp(input logic s, input logic [7:0] a,
                                         input logic [7:0] b);
    int ai;
    int bi;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    if (ai < bi) return FL;
    if (ai == bi) return FE;
    return FG;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (out_valid,L,EQ,G)", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge and update the model.
  task automatic step(input logic v, input logic s, input logic [7:0] a, input logic [7:0] b);
    in_valid  = v;
    is_signed = s;
    A         = a;
    B         = b;
    @(posedge clk);
    #1;
    exp_v = v;
    if (v) exp_f = ref_cmp(s, a, b);
  endtask

  task automatic check_model(input string tag);
    logic onehot;
    check(tag, {out_valid, L, EQ, G}, {exp_v, exp_f});
    if (out_valid) begin
      onehot = ({L, EQ, G} == FL) || ({L, EQ, G} == FE) || ({L, EQ, G} == FG);
      check({tag, "_onehot"}, {3'b000, onehot}, 4'b0001);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    A         = '0;
    B         = '0;
    exp_v     = 1'b0;
    exp_f     = 3'b000;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {out_valid, L, EQ, G}, 4'b0000);
    #3 rst_n = 1'b1;

    // After release, nothing appears until in_valid.
    step(1'b0, 1'b0, 8'h12, 8'h11);
    check("post_reset_idle0", {out_valid, L, EQ, G}, 4'b0000);
    step(1'b0, 1'b0, 8'h12, 8'h11);
    check("post_reset_idle1", {out_valid, L, EQ, G}, 4'b0000);

    // Asynchronous reset mid-cycle with G showing.
    step(1'b1, 1'b0, 8'h12, 8'h11);
    check("pre_async_g", {out_valid, L, EQ, G}, {1'b1, FG});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, L, EQ, G}, 4'b0000);

    // A compare launched while reset is held is discarded.
    in_valid = 1'b1;
    A        = 8'h44;
    B        = 8'h10;
    @(posedge clk);
    #1;
    check("inflight_discard", {out_valid, L, EQ, G}, 4'b0000);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    exp_v    = 1'b0;
    exp_f    = 3'b000;
    step(1'b0, 1'b0, 8'h44, 8'h10);
    check("post_reset2_idle", {out_valid, L, EQ, G}, 4'b0000);

    // Directed vectors back-to-back.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, dir_tbl[i][19], dir_tbl[i][18:11], dir_tbl[i][10:3]);
      check($sformatf("dir%0d", i), {out_valid, L, EQ, G}, {1'b1, dir_tbl[i][2:0]});
    end

    // Valid gating: 1,0,1 with garbage in the gap.
    step(1'b1, 1'b0, 8'h05, 8'h14);
    check("gate_first", {out_valid, L, EQ, G}, {1'b1, FL});
    step(1'b0, 1'b0, 8'h99, 8'h00);
    check("gate_hold", {out_valid, L, EQ, G}, {1'b0, FL});
    step(1'b1, 1'b0, 8'h22, 8'h22);
    check("gate_third", {out_valid, L, EQ, G}, {1'b1, FE});

    // Randomized compares; A==B forced now and then so EQ is exercised.
    for (int i = 0; i < 10000; i++) begin
      logic       v;
      logic       s;
      logic [7:0] a;
      logic [7:0] b;
      v = ($urandom_range(0, 7) != 0);
      s = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      step(v, s, a, b);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comp8_registered.md
Name: comp8_registered

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 8).
- Produces mutually exclusive one-hot flags L (A<B), EQ (A==B) and G (A>B).
- Built as a cascade of 4-bit comparator slices, 7485 style.
- Sits in the cruise-control datapath, comparing measured speed against the set-point.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- SLICE, 4, bits per cascade slice; fixed at 4, not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A, B and is_signed are sampled this cycle.
- is_signed  input  1  0 = unsigned compare; 1 = two's-complement compare.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  L/EQ/G hold the result of the last accepted inputs.
- L  output  1  A < B.
- EQ  output  1  A == B.
- G  output  1  A > B.

Behaviour:
- Reset:
  - rst_n low clears out_valid, L, EQ and G to 0 immediately, independent of clk.
  - Outputs stay 0 until the first accepted in_valid after rst_n rises.
- Latency: exactly 1 cycle.
  - in_valid high at edge N: L/EQ/G are updated at edge N and out_valid is 1 from edge N.
  - in_valid low at an edge: out_valid goes 0 and L/EQ/G hold their previous values.
- Throughput: one compare per cycle. Back-to-back in_valid is fully supported with no bubbles.
- Invariant: whenever out_valid=1, exactly one of L, EQ, G is 1.
- Unsigned mode: plain magnitude compare.
- Signed mode:
  - The MSB of each operand is inverted before entering the cascade (offset-binary trick).
  - All other logic is shared with unsigned mode.
- Cascade:
  - Slices are evaluated from the MS slice down to the LS slice.
  - A slice that finds its nibbles unequal decides the result.
  - Otherwise the slice passes the cascade-in flags through.
  - The LS slice cascade-in is fixed at EQ=1, L=0, G=0.
- Combinational compare path is one cascade deep, with no other logic before the output register.
- Reset mid-stream: any in-flight result is discarded. The first post-reset result requires a new in_valid.
- X/undefined inputs while in_valid=0 must not affect outputs.

Decomposition:
- Shared package cmp_pkg:
  - SLICE_W = 4.
  - Packed struct cmp_flags_t {lt, eq, gt}.
  - Constant CMP_CASCADE_INIT = {0,1,0}.
- Sub-module comp4_slice:
  - Inputs: two 4-bit nibbles and a cmp_flags_t cascade-in.
  - Output: cmp_flags_t.
  - Purely combinational.
- Top level: generates WIDTH/4 instances of comp4_slice, the signed-mode MSB inversion, and the output register.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs previously G=1 -> out_valid, L, EQ and G drop to 0 immediately. After release they stay 0 until the first in_valid.
- Unsigned directed set, is_signed=0, one vector per cycle with in_valid=1. Each result appears one cycle later and is one-hot:
  - 0x11 vs 0x11 -> EQ
  - 0x12 vs 0x11 -> G
  - 0x44 vs 0x10 -> G
  - 0x30 vs 0x31 -> L
  - 0x11 vs 0x10 -> G
  - 0x05 vs 0x14 -> L
  - 0x00 vs 0x00 -> EQ
- Slice boundary: compare the MS nibble against the LS nibble:
  - 0x10 vs 0x0F -> G (MS slice decides).
  - 0x3A vs 0x3B -> L (LS slice decides through the cascade).
  - 0xFF vs 0xFF -> EQ.
- Signed mode, is_signed=1:
  - 0x80 vs 0x7F -> L.
  - 0xFF vs 0x00 -> L.
  - 0x01 vs 0xFF -> G.
  - Same vectors with is_signed=0 -> G, G, L.
- Valid gating: in_valid pattern 1,0,1 with 0x05/0x14 then garbage then 0x22/0x22 -> out_valid reads 1,0,1. Flags read L, then L held, then EQ.
- Random: 10k random A, B and is_signed vectors against a reference model -> exact match, with the one-hot invariant checked every valid cycle.
